tick_scheduler: RTL and testbench

- Shared time-base controller for the board's slow-clock consumers (display refresh, debounce, blink logic).
- Runs one prescaler from clock_in and schedules up to NUM_CH derived tick/clock channels from it.
- Each channel's period is programmed at runtime over a valid/ready config port.
- Period changes take effect glitch-free at the channel's next period boundary.

---
 rtl/tick_sched_pkg.sv | 20 ++
 rtl/tick_channel.sv | 65 ++++++
 rtl/tick_scheduler.sv | 164 ++++++++++++++++
 tb/tb_tick_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick scheduler: config FSM states, the channel
// index width helper and the period code that switches a channel off.
package tick_sched_pkg;

  // Config port handshake states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_DONE = 2'd2
  } cfg_state_t;

  // A programmed period of zero disables the channel
  localparam int PERIOD_DISABLE = 0;

  // Channel index width: clog2 of the channel count, never less than one bit
  function automatic int ch_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One derived tick/clock channel. It counts base-tick wrap strobes and emits a
// registered tick every `period` strobes, toggling its square wave on each tick.
// The owner loads a new period or disables the channel; `wrap` tells the owner
// that the coming edge is this channel's tick edge so reprogramming can land
// exactly on a period boundary.
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int PER_W = 16
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             base_wrap,
  input  logic             load,
  input  logic             dis,
  input  logic [PER_W-1:0] load_period,
  output logic             tick,
  output logic             square,
  output logic             active,
  output logic             wrap
);

  logic [PER_W-1:0] period;
  logic [PER_W-1:0] count;

  assign active = (period != PER_W'(PERIOD_DISABLE));

  // The counter sits at period-1 on the base strobe that closes a period
  assign wrap = base_wrap && active && (count == period - PER_W'(1));

  // Period register and position counter; a load restarts the count so the
  // new period is measured from the edge it lands on
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      period <= '0;
      count  <= '0;
    end else if (dis) begin
      period <= PER_W'(PERIOD_DISABLE);
      count  <= '0;
    end else if (load) begin
      period <= load_period;
      count  <= '0;
    end else if (base_wrap && active) begin
      count <= wrap ? '0 : count + PER_W'(1);
    end
  end

  // Registered tick and square wave; a load on the tick edge keeps the tick
  // of the old period, while a disable parks the square wave low
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      tick   <= 1'b0;
      square <= 1'b0;
    end else if (dis) begin
      tick   <= 1'b0;
      square <= 1'b0;
    end else begin
      tick <= wrap;
      if (wrap) begin
        square <= ~square;
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Shared slow time base: a single prescaler produces a base tick every
// PRESCALE clocks and NUM_CH channels derive their own ticks and square waves
// from it. Channel periods are reprogrammed through a valid/ready port; a
// change to a running channel waits for that channel's next tick edge so its
// output never sees a shortened or stretched period.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int PRESCALE = 25000000,
  parameter int NUM_CH   = 4,
  parameter int PER_W    = 16
) (
  input  logic                        clock_in,
  input  logic                        reset,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [ch_width(NUM_CH)-1:0] cfg_ch,
  input  logic [PER_W-1:0]            cfg_period,
  output logic                        cfg_done,
  output logic                        cfg_err,
  output logic                        base_tick,
  output logic [NUM_CH-1:0]           ch_tick,
  output logic [NUM_CH-1:0]           ch_clk,
  output logic [NUM_CH-1:0]           ch_active
);

  localparam int CH_W = ch_width(NUM_CH);
  localparam int PS_W = $clog2(PRESCALE);

  // Prescaler
  logic [PS_W-1:0] ps_count;
  logic            ps_wrap;

  // Config FSM and holding registers
  cfg_state_t       state;
  cfg_state_t       state_next;
  logic [CH_W-1:0]  ch_hold;
  logic [PER_W-1:0] period_hold;
  logic             err_hold;
  logic             accept;
  logic             pending;
  logic             is_disable;
  logic             sel_active;
  logic             sel_wrap;
  logic             apply;

  // Per-channel control and status
  logic [NUM_CH-1:0] sel_vec;
  logic [NUM_CH-1:0] wrap_vec;
  logic [NUM_CH-1:0] load_vec;
  logic [NUM_CH-1:0] dis_vec;

  assign ps_wrap = (ps_count == PS_W'(PRESCALE - 1));

  // Free-running prescaler counting 0..PRESCALE-1
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      ps_count <= '0;
    end else begin
      ps_count <= ps_wrap ? '0 : ps_count + PS_W'(1);
    end
  end

  // Base tick is the registered wrap strobe, so it lines up with channel ticks
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      base_tick <= 1'b0;
    end else begin
      base_tick <= ps_wrap;
    end
  end

  assign accept = cfg_valid && cfg_ready;

  // Request capture; the port is ignored until the FSM returns to IDLE
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      ch_hold     <= '0;
      period_hold <= '0;
      err_hold    <= 1'b0;
    end else if (accept) begin
      ch_hold     <= cfg_ch;
      period_hold <= cfg_period;
      err_hold    <= (int'(cfg_ch) >= NUM_CH);
    end
  end

  // Decode of the held request against the target channel's state
  assign pending    = (state == ST_PEND) && !err_hold;
  assign is_disable = (period_hold == PER_W'(PERIOD_DISABLE));
  assign sel_active = |(ch_active & sel_vec);
  assign sel_wrap   = |(wrap_vec & sel_vec);

  // A held request completes at once unless it must wait for a running
  // channel's tick edge
  assign apply = (state == ST_PEND) &&
                 (err_hold || is_disable || !sel_active || sel_wrap);

  // FSM state register
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_next = state;
    cfg_ready  = 1'b0;
    cfg_done   = 1'b0;
    cfg_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        if (apply) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        cfg_done   = 1'b1;
        cfg_err    = err_hold;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign sel_vec[gi] = (ch_hold == CH_W'(gi));

      // Idle channels load immediately; running ones load on their tick edge
      assign load_vec[gi] = pending && sel_vec[gi] && !is_disable &&
                            (!ch_active[gi] || wrap_vec[gi]);
      assign dis_vec[gi]  = pending && sel_vec[gi] && is_disable;

      tick_channel #(
        .PER_W(PER_W)
      ) u_ch (
        .clock_in    (clock_in),
        .reset       (reset),
        .base_wrap   (ps_wrap),
        .load        (load_vec[gi]),
        .dis         (dis_vec[gi]),
        .load_period (period_hold),
        .tick        (ch_tick[gi]),
        .square      (ch_clk[gi]),
        .active      (ch_active[gi]),
        .wrap        (wrap_vec[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with PRESCALE=4, three channels and 8-bit
// periods. Cycle k is the cycle after the k-th rising edge since reset release.
// Expected config completions and channel ticks are queued up front; a monitor
// on the falling edge pops and compares whenever the DUT shows an event.
module tb_tick_scheduler;

  localparam int PRESCALE = 4;
  localparam int NUM_CH   = 3;
  localparam int PER_W    = 8;

  logic             clock_in   = 1'b0;
  logic             reset      = 1'b1;
  logic             cfg_valid  = 1'b0;
  logic [1:0]       cfg_ch     = '0;
  logic [PER_W-1:0] cfg_period = '0;
  logic             cfg_ready;
  logic             cfg_done;
  logic             cfg_err;
  logic             base_tick;
  logic [NUM_CH-1:0] ch_tick;
  logic [NUM_CH-1:0] ch_clk;
  logic [NUM_CH-1:0] ch_active;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int cyc;
    bit val;
  } ev_t;

  ev_t done_q[$];
  ev_t tick0_q[$];
  ev_t tick1_q[$];
  ev_t ev_m;

  tick_scheduler #(
    .PRESCALE(PRESCALE),
    .NUM_CH  (NUM_CH),
    .PER_W   (PER_W)
  ) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_period(cfg_period),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .base_tick (base_tick),
    .ch_tick   (ch_tick),
    .ch_clk    (ch_clk),
    .ch_active (ch_active)
  );

  always #5 clock_in = ~clock_in;

  // Cycle index since reset release
  always @(posedge clock_in or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor: base tick cadence, channel ticks and config completions
  always @(negedge clock_in) begin
    if (!reset) begin
      check("base_tick", int'(base_tick), (cyc > 0 && cyc % PRESCALE == 0) ? 1 : 0);

      if (tick0_q.size() > 0 && tick0_q[0].cyc < cyc) begin
        ev_m = tick0_q.pop_front();
        check("ch0_tick_missing_cycle", cyc, ev_m.cyc);
      end
      if (ch_tick[0]) begin
        if (tick0_q.size() == 0) check("ch0_tick_unexpected", cyc, -1);
        else begin
          ev_m = tick0_q.pop_front();
          check("ch0_tick_cycle", cyc, ev_m.cyc);
          check("ch0_clk_at_tick", int'(ch_clk[0]), int'(ev_m.val));
        end
      end

      if (tick1_q.size() > 0 && tick1_q[0].cyc < cyc) begin
        ev_m = tick1_q.pop_front();
        check("ch1_tick_missing_cycle", cyc, ev_m.cyc);
      end
      if (ch_tick[1]) begin
        if (tick1_q.size() == 0) check("ch1_tick_unexpected", cyc, -1);
        else begin
          ev_m = tick1_q.pop_front();
          check("ch1_tick_cycle", cyc, ev_m.cyc);
          check("ch1_clk_at_tick", int'(ch_clk[1]), int'(ev_m.val));
        end
      end

      if (ch_tick[2]) check("ch2_tick_unexpected", cyc, -1);

      if (done_q.size() > 0 && done_q[0].cyc < cyc) begin
        ev_m = done_q.pop_front();
        check("cfg_done_missing_cycle", cyc, ev_m.cyc);
      end
      if (cfg_done) begin
        if (done_q.size() == 0) check("cfg_done_unexpected", cyc, -1);
        else begin
          ev_m = done_q.pop_front();
          check("cfg_done_cycle", cyc, ev_m.cyc);
          check("cfg_err", int'(cfg_err), int'(ev_m.val));
        end
      end else if (cfg_err) begin
        check("cfg_err_without_done", int'(cfg_err), int'(cfg_done));
      end
    end
  end

  // Advance to just after rising edge n (bounded)
  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 1000) begin
      @(posedge clock_in);
      #1;
      guard++;
    end
    if (cyc < n) check("wait_cyc_timeout", cyc, n);
  endtask

  // Offer one request in the current cycle and hold it until accepted
  task automatic send(input int ch, input int per, input int acc_cyc,
                      input int done_cyc, input bit err, input bit push_done);
    int guard;
    cfg_ch     = 2'(ch);
    cfg_period = PER_W'(per);
    cfg_valid  = 1'b1;
    if (push_done) done_q.push_back('{done_cyc, err});
    guard = 0;
    @(negedge clock_in);
    while (!cfg_ready && guard < 50) begin
      @(negedge clock_in);
      guard++;
    end
    @(posedge clock_in);
    #1;
    cfg_valid = 1'b0;
    $display("req ch=%0d period=%0d accepted at edge %0d", ch, per, cyc);
    check("accept_cycle", cyc, acc_cyc);
  endtask

  initial begin
    // ch0: period 3 loaded at edge 11, ticks at 20 then 32 (old spacing),
    // then period 1 ticks every 4 cycles until the mid-test reset
    tick0_q.push_back('{20, 1'b1});
    tick0_q.push_back('{32, 1'b0});
    for (int c = 36; c <= 84; c += 4) tick0_q.push_back('{c, bit'(((c - 32) / 4) % 2)});
    // ch1: period 2 loaded at edge 46, disabled at edge 71
    tick1_q.push_back('{52, 1'b1});
    tick1_q.push_back('{60, 1'b0});
    tick1_q.push_back('{68, 1'b1});

    repeat (3) @(posedge clock_in);
    #3 reset = 1'b0;

    wait_cyc(2);
    check("ready_after_reset", int'(cfg_ready), 1);
    check("active_after_reset", int'(ch_active), 0);
    check("clk_after_reset", int'(ch_clk), 0);

    wait_cyc(9);
    send(0, 3, 10, 11, 1'b0, 1'b1);
    wait_cyc(12);
    check("active_ch0_on", int'(ch_active), 1);

    wait_cyc(24);
    send(0, 1, 25, 32, 1'b0, 1'b1);
    wait_cyc(28);
    check("ready_low_while_waiting", int'(cfg_ready), 0);

    wait_cyc(40);
    send(3, 5, 41, 42, 1'b1, 1'b1);

    wait_cyc(44);
    send(1, 2, 45, 46, 1'b0, 1'b1);
    wait_cyc(47);
    check("active_ch0_ch1", int'(ch_active), 3);

    wait_cyc(69);
    check("ch1_clk_before_disable", int'(ch_clk[1]), 1);
    send(1, 0, 70, 71, 1'b0, 1'b1);
    wait_cyc(72);
    check("active_after_disable", int'(ch_active), 1);
    check("ch1_clk_after_disable", int'(ch_clk[1]), 0);

    wait_cyc(85);
    send(0, 2, 86, 0, 1'b0, 1'b0);
    check("ready_low_in_pend", int'(cfg_ready), 0);
    check("ch0_clk_before_reset", int'(ch_clk[0]), 1);
    check("done_q_left", done_q.size(), 0);
    check("tick0_q_left", tick0_q.size(), 0);
    check("tick1_q_left", tick1_q.size(), 0);

    #1 reset = 1'b1;
    #1;
    check("outs_in_reset", int'({base_tick, cfg_done, cfg_err, ch_tick}), 0);
    check("ch_clk_in_reset", int'(ch_clk), 0);
    check("ch_active_in_reset", int'(ch_active), 0);

    repeat (2) @(posedge clock_in);
    #3 reset = 1'b0;
    wait_cyc(1);
    check("ready_after_rerelease", int'(cfg_ready), 1);
    check("active_after_rerelease", int'(ch_active), 0);
    wait_cyc(14);
    check("done_q_final", done_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
